program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 100, number of valid instruction addresses (0..ROM_DEPTH-1).
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset (must be < ROM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  decoder did not accept the current instruction.
REQ-006 SHALL have port branch_en  input  1  current instruction redirects fetch.
REQ-007 SHALL have port branch_target  input  16  redirect address.
REQ-008 SHALL have port halt  input  1  current instruction is HLT.
REQ-009 SHALL have port pco_out  output  16  registered fetch address to the instruction ROM.
REQ-010 SHALL have port ir_pc  output  16  address of the instruction currently on the ROM output.
REQ-011 SHALL have port instr_valid  output  1  ROM output holds an in-path instruction.
REQ-012 SHALL have port halted  output  1  high in HALT state.
REQ-013 SHALL have port fault  output  1  high in FAULT state.

Function
REQ-014 SHALL assume the ROM registers rom[pco_out] on each posedge (1-cycle latency, no enable, no reset); the registered ir_pc and instr_valid SHALL describe that ROM output in the same cycle.
REQ-015 SHALL implement states RUN, HALT and FAULT; halted = (state==HALT); fault = (state==FAULT).
REQ-016 SHALL honour stall, halt and branch_en only when instr_valid=1 in RUN; otherwise it SHALL ignore them.
REQ-017 SHALL, on every edge in RUN, load ir_pc <= pco_out.
REQ-018 SHALL apply the following priority to honoured inputs: stall > halt > branch_en > sequential.
REQ-019 Sequential: pco_out <= (pco_out==ROM_DEPTH-1) ? 0 : pco_out+1; instr_valid <= 1.
REQ-020 Stall (replay): pco_out <= ir_pc; instr_valid <= 0; two-cycle penalty before ir_pc's instruction reappears valid.
REQ-021 Branch with branch_target < ROM_DEPTH: pco_out <= branch_target; instr_valid <= 0 (flushes the wrong-path fetch).
REQ-022 Branch with branch_target >= ROM_DEPTH: state <= FAULT; pco_out holds; instr_valid <= 0.
REQ-023 Halt: state <= HALT; pco_out holds; instr_valid <= 0.
REQ-024 SHALL, in HALT or FAULT, hold pco_out and ir_pc, keep instr_valid=0, ignore all inputs, and leave only via rst.
REQ-025 SHALL never drive pco_out >= ROM_DEPTH.

Reset
REQ-026 SHALL, when rst=1 at an edge, override all other inputs in any state: pco_out<=RESET_PC, ir_pc<=0, instr_valid<=0, state<=RUN, halted=0, fault=0.
REQ-027 SHALL assert instr_valid=1 with ir_pc=RESET_PC on the second edge after rst deasserts, provided no stall/branch/halt is honoured in between.

Verification
REQ-028 Reset then free run: pco_out 0,1,2,...; instr_valid rises one cycle after pco_out=0; ir_pc lags pco_out by exactly one cycle.
REQ-029 Wrap: run to pco_out=99 -> next pco_out=0; ir_pc sequence ...,98,99,0 with instr_valid held at 1.
REQ-030 Stall with ir_pc=4, pco_out=5 -> next cycle pco_out=4, instr_valid=0; following cycle ir_pc=4, instr_valid=1.
REQ-031 Branch to 40 with ir_pc=10 -> next cycle pco_out=40, instr_valid=0; then ir_pc=40, instr_valid=1. Branch to 120 -> fault=1, instr_valid=0, pco_out frozen.
REQ-032 Priority: stall+halt+branch_en together -> replay only. halt alone -> halted=1, pco_out frozen. Any input while instr_valid=0 -> ignored.
REQ-033 rst asserted in HALT, in FAULT, and in mid-replay -> all cases return to pco_out=0, instr_valid=0, halted=0, fault=0 on the next edge.

Source files
------------

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Fetch-address generator for a synchronous instruction ROM
//               with one cycle of read latency. pco_out addresses the ROM;
//               ir_pc and instr_valid describe the word the ROM presents in
//               the same cycle. Supports replay on stall, branch redirect,
//               halt, and a fault state for out-of-range branch targets.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROM_DEPTH     : number of valid instruction addresses (0..ROM_DEPTH-1)
//   RESET_PC      : first fetch address after reset (< ROM_DEPTH)
// Ports
//   clk           : in  1   clock, all state updates on posedge
//   rst           : in  1   synchronous active-high reset
//   stall         : in  1   decoder did not accept the current instruction
//   branch_en     : in  1   current instruction redirects fetch
//   branch_target : in  16  redirect address
//   halt          : in  1   current instruction is HLT
//   pco_out       : out 16  registered fetch address to the ROM
//   ir_pc         : out 16  address of the instruction on the ROM output
//   instr_valid   : out 1   ROM output holds an in-path instruction
//   halted        : out 1   high in HALT state
//   fault         : out 1   high in FAULT state
// ============================================================================
module program_counter #(
  parameter int ROM_DEPTH = 100,
  parameter int RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  input  logic        halt,
  output logic [15:0] pco_out,
  output logic [15:0] ir_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [15:0] c_LAST_PC  = 16'(ROM_DEPTH - 1);
  localparam logic [15:0] c_RESET_PC = 16'(RESET_PC);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pco;
  logic [15:0] r_ir_pc;
  logic        r_valid;

  state_t      w_state_nxt;
  logic [15:0] w_pco_nxt;
  logic [15:0] w_ir_pc_nxt;
  logic        w_valid_nxt;
  logic [15:0] w_pco_seq;
  logic        w_honour;
  logic        w_target_ok;

  // Control inputs refer to the instruction on the ROM output, so they only
  // mean something when that word is valid and we are running.
  assign w_honour    = (r_state == S_RUN) && r_valid;
  assign w_pco_seq   = (r_pco == c_LAST_PC) ? 16'd0 : r_pco + 16'd1;
  assign w_target_ok = (branch_target <= c_LAST_PC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pco   <= c_RESET_PC;
      r_ir_pc <= 16'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pco   <= w_pco_nxt;
      r_ir_pc <= w_ir_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pco_nxt   = r_pco;
    w_ir_pc_nxt = r_ir_pc;
    w_valid_nxt = 1'b0;

    case (r_state)
      S_RUN: begin
        // The ROM always captures rom[pco_out], so its address tracks.
        w_ir_pc_nxt = r_pco;
        if (w_honour && stall) begin
          // Replay: refetch the rejected word; the word already in flight
          // (at pco_out) is discarded, hence the two-cycle penalty.
          w_pco_nxt   = r_ir_pc;
        end else if (w_honour && halt) begin
          w_state_nxt = S_HALT;
        end else if (w_honour && branch_en) begin
          if (w_target_ok) begin
            w_pco_nxt   = branch_target;
          end else begin
            w_state_nxt = S_FAULT;
          end
        end else begin
          w_pco_nxt   = w_pco_seq;
          w_valid_nxt = 1'b1;
        end
      end
      S_HALT, S_FAULT: begin
        // Frozen until reset.
      end
      default: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  assign pco_out     = r_pco;
  assign ir_pc       = r_ir_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Self-checking bench for program_counter (ROM_DEPTH=100,
//               RESET_PC=0) using a table of directed vectors plus a
//               free-run/wrap sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        halt;
  logic [15:0] pco_out;
  logic [15:0] ir_pc;
  logic        instr_valid;
  logic        halted;
  logic        fault;

  int n_tests;
  int n_fail;

  program_counter #(
    .ROM_DEPTH (100),
    .RESET_PC  (0)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .halt          (halt),
    .pco_out       (pco_out),
    .ir_pc         (ir_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        halt;
    logic [15:0] tgt;
    logic [15:0] pco;
    logic [15:0] ir;
    logic        v;
    logic        h;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic b,
                              input logic hl, input int t, input int p,
                              input int i, input logic v, input logic h,
                              input logic f);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.halt = hl; x.tgt = 16'(t);
    x.pco = 16'(p); x.ir = 16'(i); x.v = v; x.h = h; x.f = f;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] ep,
                       input logic [15:0] ei, input logic ev,
                       input logic eh, input logic ef);
    n_tests++;
    if ({pco_out, ir_pc, instr_valid, halted, fault} !== {ep, ei, ev, eh, ef}) begin
      n_fail++;
      $display("FAIL %s: got pco=%0d ir=%0d v=%b h=%b f=%b, expected pco=%0d ir=%0d v=%b h=%b f=%b",
               name, pco_out, ir_pc, instr_valid, halted, fault, ep, ei, ev, eh, ef);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 16'd0; halt = 1'b0;

    //                rst stl br hlt tgt  pco ir  v  h  f
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,  0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   3,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   4,  3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   5,  4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,   0,   4,  5, 0, 0, 0)); // stall ir=4 pco=5
    vecs.push_back(mk(0, 0, 0, 0,   0,   5,  4, 1, 0, 0)); // ir 4 reappears
    vecs.push_back(mk(0, 1, 1, 1,  40,   4,  5, 0, 0, 0)); // all three: replay
    vecs.push_back(mk(0, 1, 1, 1,  40,   5,  4, 1, 0, 0)); // invalid: ignored
    vecs.push_back(mk(0, 0, 0, 0,   0,   6,  5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   7,  6, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   8,  7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,   9,  8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,  10,  9, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0,  11, 10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  40,  40, 11, 0, 0, 0)); // branch 40 at ir=10
    vecs.push_back(mk(0, 0, 0, 0,   0,  41, 40, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 120,  41, 41, 0, 0, 1)); // out-of-range -> fault
    vecs.push_back(mk(0, 1, 1, 1,  50,  41, 41, 0, 0, 1)); // fault ignores inputs
    vecs.push_back(mk(1, 1, 1, 1,  50,   0,  0, 0, 0, 0)); // rst in fault
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,   0,   1,  1, 0, 1, 0)); // halt alone
    vecs.push_back(mk(0, 1, 1, 0,  30,   1,  1, 0, 1, 0)); // halt ignores inputs
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,  0, 0, 0, 0)); // rst in halt
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,   0,   0,  1, 0, 0, 0)); // stall -> replay
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,  0, 0, 0, 0)); // rst mid-replay
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  99,  99,  1, 0, 0, 0)); // branch to last addr
    vecs.push_back(mk(0, 0, 0, 0,   0,   0, 99, 1, 0, 0)); // wrap
    vecs.push_back(mk(0, 0, 0, 0,   0,   1,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 100,   1,  1, 0, 0, 1)); // target==ROM_DEPTH faults

    foreach (vecs[k]) begin
      rst           = vecs[k].rst;
      stall         = vecs[k].stall;
      branch_en     = vecs[k].br;
      halt          = vecs[k].halt;
      branch_target = vecs[k].tgt;
      step();
      check($sformatf("vec%0d", k), vecs[k].pco, vecs[k].ir, vecs[k].v,
            vecs[k].h, vecs[k].f);
    end

    // Free run from reset across the wrap point.
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; halt = 1'b0; branch_target = 16'd0;
    step();
    check("run_reset", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      step();
      check($sformatf("run%0d", k), 16'(k % 100), 16'((k - 1) % 100), 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
